wdt_ctrl: RTL

Register front end and sequencer for the watchdog timer. Accepts CPU writes on a simple single-cycle register port and drives the watchdog's enable, kick and timeout-count inputs. Monitors its timeout output and escalates a timeout in two stages: first an interrupt, then, if the CPU does not kick before the grace window ends, a fixed-width system reset request. Sits between the peripheral bus decoder and the watchdog counter, in the same clock domain.

---
 rtl/wdt_pkg.sv | 31 +++
 rtl/wdt_ctrl_cnt.sv | 28 ++
 rtl/wdt_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_pkg.sv
// wdt_pkg: shared types and constants for the watchdog register front end.
// Holds the sequencer state encoding (also visible in STATUS[3:2]), the
// register word addresses and the magic value that counts as a kick.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    GRACE  = 2'd2,
    RSTREQ = 2'd3
  } wdt_state_e;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd1;
  localparam logic [2:0] ADDR_KICK    = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_GRACE   = 3'd4;

  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

  // Kicks are honoured only while the watchdog is actually counting.
  function automatic logic is_active(input wdt_state_e s);
    return (s == RUN) || (s == GRACE);
  endfunction

  // STATUS layout: [3:2] state, [1] reserved, [0] TO_FLAG.
  function automatic logic [31:0] pack_status(input wdt_state_e s, input logic to_flag);
    return {28'd0, s, 1'b0, to_flag};
  endfunction

endpackage

// File: rtl/wdt_ctrl_cnt.sv
// wdt_ctrl_cnt: loadable 16-bit down-counter with a zero flag.
// Load has priority over counting; counting stops at zero rather than
// wrapping, so the zero flag stays asserted until the next load.
module wdt_ctrl_cnt (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] count;

  // Count register: reload on demand, otherwise step down while enabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: register front end and timeout sequencer for the watchdog.
// Decodes CPU register accesses, drives enable/kick/timeout-count to the
// watchdog counter and escalates a timeout first to IRQ, then, if no kick
// arrives within the grace window, to a fixed-length SYS_RST_REQ pulse.
// Optional feature macro: WDT_CTRL_LOCK_EN (adds the sticky CTRL.LOCK bit).
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter logic [31:0] TO_RST    = 32'h0000_FFFF,
  parameter logic [15:0] GRACE_RST = 16'd1024,
  parameter int          RST_PULSE = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [2:0]  ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        RVALID,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        WTO,
  output logic        IRQ,
  output logic        SYS_RST_REQ
);

  // The pulse counter is loaded with one less than the pulse length because
  // the RSTREQ cycle that observes zero is itself part of the pulse.
  localparam logic [15:0] PULSE_LOAD = 16'(RST_PULSE - 1);

  wdt_state_e  state_q;
  wdt_state_e  state_nxt;

  logic        en_q;
  logic        to_flag_q;
  logic [31:0] timeout_q;
  logic [15:0] grace_q;
  logic [1:0]  blank_q;

  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic        ctrl_wr_ok;
  logic        ctrl_lock_bit;
  logic        cfg_wr;
  logic        kick_ok;
  logic        w1c;
  logic        blanked;
  logic        wto_hit;
  logic        en_clr;
  logic        en_set;

  logic        grace_load;
  logic        grace_run;
  logic        grace_zero;
  logic        pulse_load;
  logic        pulse_run;
  logic        pulse_zero;
  logic        pulse_done;

  logic        wden_nxt;
  logic        irq_nxt;
  logic        sysrst_nxt;
  logic [31:0] rdata_mux;

  // Access decode; the whole register file is frozen during the reset request.
  assign wr      = REQ && WE && (state_q != RSTREQ);
  assign rd      = REQ && !WE;
  assign ctrl_wr = wr && (ADDR == ADDR_CTRL) && ctrl_wr_ok;
  assign cfg_wr  = wr && (state_q == IDLE);
  assign kick_ok = wr && (ADDR == ADDR_KICK) && (WDATA == KICK_KEY) && is_active(state_q);
  assign w1c     = wr && (ADDR == ADDR_STATUS) && WDATA[0];
  assign en_set  = ctrl_wr && WDATA[0];
  assign en_clr  = ctrl_wr && !WDATA[0];

  // The watchdog's timeout flag lags a kick or an enable, so it is masked
  // while the blanking counter is non-zero.
  assign blanked = (blank_q != 2'd0);
  assign wto_hit = WTO && !blanked;

  assign grace_load = (state_q == RUN) && (state_nxt == GRACE);
  assign grace_run  = (state_q == GRACE);
  assign pulse_load = (state_q == GRACE) && (state_nxt == RSTREQ);
  assign pulse_run  = (state_q == RSTREQ);
  assign pulse_done = (state_q == RSTREQ) && (state_nxt == IDLE);

`ifdef WDT_CTRL_LOCK_EN
  logic lock_q;

  // Sticky lock: once set on an enabling CTRL write, CTRL is read-only
  // until system reset or the end of a reset request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q <= 1'b0;
    end else if (pulse_done) begin
      lock_q <= 1'b0;
    end else if (ctrl_wr && WDATA[1] && WDATA[0]) begin
      lock_q <= 1'b1;
    end
  end

  assign ctrl_wr_ok    = !lock_q;
  assign ctrl_lock_bit = lock_q;
`else
  assign ctrl_wr_ok    = 1'b1;
  assign ctrl_lock_bit = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; the branch order encodes the simultaneous-event
  // priorities (disable beats everything, a kick beats WTO and expiry).
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (en_set) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (en_clr) begin
          state_nxt = IDLE;
        end else if (kick_ok) begin
          state_nxt = RUN;
        end else if (wto_hit) begin
          state_nxt = GRACE;
        end
      end
      GRACE: begin
        if (en_clr) begin
          state_nxt = IDLE;
        end else if (kick_ok) begin
          state_nxt = RUN;
        end else if (grace_zero) begin
          state_nxt = RSTREQ;
        end
      end
      RSTREQ: begin
        if (pulse_zero) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line
  // up with the state register.
  always_comb begin
    wden_nxt   = 1'b0;
    irq_nxt    = 1'b0;
    sysrst_nxt = 1'b0;
    case (state_nxt)
      RUN:     wden_nxt   = 1'b1;
      GRACE: begin
        wden_nxt = 1'b1;
        irq_nxt  = 1'b1;
      end
      RSTREQ:  sysrst_nxt = 1'b1;
      default: wden_nxt   = 1'b0;
    endcase
  end

  // Registered watchdog-facing outputs and the kick pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WDEN        <= 1'b0;
      IRQ         <= 1'b0;
      SYS_RST_REQ <= 1'b0;
      WDLIVE      <= 1'b0;
    end else begin
      WDEN        <= wden_nxt;
      IRQ         <= irq_nxt;
      SYS_RST_REQ <= sysrst_nxt;
      WDLIVE      <= kick_ok;
    end
  end

  // CTRL.EN tracks the last accepted CTRL write and is dropped when a
  // reset request completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q <= 1'b0;
    end else if (pulse_done) begin
      en_q <= 1'b0;
    end else if (ctrl_wr) begin
      en_q <= WDATA[0];
    end
  end

  // Configuration registers and the timeout flag; a new timeout wins
  // over a simultaneous write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timeout_q <= TO_RST;
      grace_q   <= GRACE_RST;
      to_flag_q <= 1'b0;
    end else begin
      if (cfg_wr && (ADDR == ADDR_TIMEOUT)) begin
        timeout_q <= WDATA;
      end
      if (cfg_wr && (ADDR == ADDR_GRACE)) begin
        grace_q <= WDATA[15:0];
      end
      if (grace_load) begin
        to_flag_q <= 1'b1;
      end else if (w1c) begin
        to_flag_q <= 1'b0;
      end
    end
  end

  assign WTOCNT = timeout_q;

  // Blanking counter: covers the kick cycle plus two, or two cycles after enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blank_q <= 2'd0;
    end else if (kick_ok) begin
      blank_q <= 2'd3;
    end else if ((state_q == IDLE) && (state_nxt == RUN)) begin
      blank_q <= 2'd2;
    end else if (blank_q != 2'd0) begin
      blank_q <= blank_q - 2'd1;
    end
  end

  // Read data selection; KICK and unmapped addresses read as zero.
  always_comb begin
    rdata_mux = 32'd0;
    case (ADDR)
      ADDR_CTRL:    rdata_mux = {30'd0, ctrl_lock_bit, en_q};
      ADDR_TIMEOUT: rdata_mux = timeout_q;
      ADDR_STATUS:  rdata_mux = pack_status(state_q, to_flag_q);
      ADDR_GRACE:   rdata_mux = {16'd0, grace_q};
      default:      rdata_mux = 32'd0;
    endcase
  end

  // Registered read port; RDATA holds its last value between reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA  <= 32'd0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= rd;
      if (rd) begin
        RDATA <= rdata_mux;
      end
    end
  end

  wdt_ctrl_cnt u_grace_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (grace_load),
    .en       (grace_run),
    .load_val (grace_q),
    .zero     (grace_zero)
  );

  wdt_ctrl_cnt u_pulse_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (pulse_load),
    .en       (pulse_run),
    .load_val (PULSE_LOAD),
    .zero     (pulse_zero)
  );

endmodule
